// File: rtl/credit_return_if.sv
// Credit return handshake between a receive buffer's credit manager and the upstream sender.
interface credit_return_if #(
   parameter int COUNT_WIDTH = 5
);
   logic                   ret_valid;
   logic                   ret_ready;
   logic [COUNT_WIDTH-1:0] ret_count;

   modport master (
      output ret_valid,
      output ret_count,
      input  ret_ready
   );

   modport slave (
      input  ret_valid,
      input  ret_count,
      output ret_ready
   );
endinterface

// File: rtl/credit_return.sv
// Receiver-side credit manager: counts freed slots and returns them upstream in batches.
// Optional idle-timeout partial flush is enabled by defining CREDIT_RETURN_TIMEOUT_EN.
module credit_return #(
   parameter int DEPTH       = 16,
   parameter int BATCH       = 4,
   parameter int COUNT_WIDTH = 5,
   parameter int TIMEOUT     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   free_in,
   credit_return_if.master        ret,
   output logic [COUNT_WIDTH-1:0] pending,
   output logic                   err_ovf
);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;

   localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);
   localparam logic [COUNT_WIDTH-1:0] BATCH_C = COUNT_WIDTH'(BATCH);
   localparam logic [COUNT_WIDTH:0]   DEPTH_W = (COUNT_WIDTH+1)'(DEPTH);

   logic [1:0]             state;
   logic                   transfer;
   logic [COUNT_WIDTH-1:0] sub;
   logic [COUNT_WIDTH:0]   sum;
   logic [COUNT_WIDTH-1:0] pending_next;
   logic                   ovf_hit;
   logic                   batch_ready;
   logic                   timeout_hit;

   // Credits leave only on an accepted SEND packet; the INIT advertisement is not backed by pending.
   always_comb begin
      transfer     = ret.ret_valid & ret.ret_ready;
      sub          = (transfer && state == ST_SEND) ? ret.ret_count : '0;
      sum          = {1'b0, pending} + {{COUNT_WIDTH{1'b0}}, free_in} - {1'b0, sub};
      pending_next = sum[COUNT_WIDTH-1:0];
      ovf_hit      = 1'b0;
      if (sum > DEPTH_W) begin
         pending_next = DEPTH_C;
         ovf_hit      = 1'b1;
      end
      batch_ready  = (pending_next >= BATCH_C);
   end

`ifdef CREDIT_RETURN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT) + 1;

   logic [TW-1:0] timer;
   logic          timer_run;

   always_comb begin
      timer_run   = (state == ST_ACCUM) && (pending != '0) && (pending < BATCH_C) && !free_in;
      timeout_hit = timer_run && (timer == TW'(TIMEOUT - 1));
   end

   // Any break in the idle stretch restarts the countdown from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer <= '0;
      end else if (timer_run && !timeout_hit) begin
         timer <= timer + 1'b1;
      end else begin
         timer <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_INIT;
         ret.ret_valid <= 1'b0;
         ret.ret_count <= '0;
         pending       <= '0;
         err_ovf       <= 1'b0;
      end else begin
         pending <= pending_next;
         if (ovf_hit) begin
            err_ovf <= 1'b1;
         end
         case (state)
            ST_INIT: begin
               if (!ret.ret_valid) begin
                  ret.ret_valid <= 1'b1;
                  ret.ret_count <= DEPTH_C;
               end else if (ret.ret_ready) begin
                  state         <= ST_ACCUM;
                  ret.ret_valid <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (batch_ready) begin
                  state         <= ST_SEND;
                  ret.ret_valid <= 1'b1;
                  ret.ret_count <= BATCH_C;
               end else if (timeout_hit) begin
                  state         <= ST_SEND;
                  ret.ret_valid <= 1'b1;
                  ret.ret_count <= pending;
               end
            end
            ST_SEND: begin
               // Chain the next full batch straight after an accepted one, with no idle cycle.
               if (transfer) begin
                  if (batch_ready) begin
                     ret.ret_count <= BATCH_C;
                  end else begin
                     state         <= ST_ACCUM;
                     ret.ret_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state         <= ST_INIT;
               ret.ret_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_credit_return.sv
// Self-checking bench for credit_return; returned packets are scored against an expected-count queue.
module tb_credit_return;

   logic       clk = 1'b0;
   logic       rst;
   logic       free_in;
   logic [4:0] pending;
   logic       err_ovf;

   int checks = 0;
   int fails  = 0;
   int exp_q[$];

   credit_return_if #(.COUNT_WIDTH(5)) ret_if ();

   credit_return #(
      .DEPTH(16),
      .BATCH(4),
      .COUNT_WIDTH(5),
      .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .free_in(free_in),
      .ret(ret_if.master),
      .pending(pending),
      .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   // Every accepted packet must match the oldest expected credit count.
   always @(negedge clk) begin
      int e;
      if (rst === 1'b1 && ret_if.ret_valid === 1'b1 && ret_if.ret_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_packet: got ret_count=%0d, required no packet", ret_if.ret_count);
         end else begin
            e = exp_q.pop_front();
            if (ret_if.ret_count !== 5'(e)) begin
               fails++;
               $display("[TB] FAIL packet_count: got %0d, required %0d", ret_if.ret_count, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_queue_empty(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL %s: got %0d packets outstanding, required 0", name, exp_q.size());
      end
   endtask

   task automatic reset_dut();
      rst              = 1'b0;
      free_in          = 1'b0;
      ret_if.ret_ready = 1'b1;
      exp_q.delete();
      tick();
      tick();
      rst = 1'b1;
      exp_q.push_back(16);
      tick();
      tick();
      checks++;
      if (ret_if.ret_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_dut_ack: got ret_valid=%b, required 0", ret_if.ret_valid);
      end
      check_queue_empty("reset_dut_queue");
   endtask

   task automatic test_reset();
      rst              = 1'b0;
      free_in          = 1'b0;
      ret_if.ret_ready = 1'b0;
      tick();
      tick();
      checks += 4;
      if (ret_if.ret_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b, required 0", ret_if.ret_valid); end
      if (ret_if.ret_count !== 5'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d, required 0", ret_if.ret_count); end
      if (pending !== 5'd0)          begin fails++; $display("[TB] FAIL reset_pending: got %0d, required 0", pending); end
      if (err_ovf !== 1'b0)          begin fails++; $display("[TB] FAIL reset_err: got %b, required 0", err_ovf); end
      exp_q.push_back(16);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks += 2;
         if (ret_if.ret_valid !== 1'b1) begin fails++; $display("[TB] FAIL init_valid[%0d]: got %b, required 1", i, ret_if.ret_valid); end
         if (ret_if.ret_count !== 5'd16) begin fails++; $display("[TB] FAIL init_count[%0d]: got %0d, required 16", i, ret_if.ret_count); end
      end
      ret_if.ret_ready = 1'b1;
      tick();
      checks++;
      if (ret_if.ret_valid !== 1'b0) begin fails++; $display("[TB] FAIL init_accept: got ret_valid=%b, required 0", ret_if.ret_valid); end
      check_queue_empty("init_queue");
   endtask

   task automatic test_batch();
      ret_if.ret_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(4);
         free_in = 1'b1;
         tick();
         free_in = 1'b0;
         if (i < 3) begin
            checks += 2;
            if (pending !== 5'(i + 1)) begin fails++; $display("[TB] FAIL batch_pending[%0d]: got %0d, required %0d", i, pending, i + 1); end
            if (ret_if.ret_valid !== 1'b0) begin fails++; $display("[TB] FAIL batch_early_valid[%0d]: got %b, required 0", i, ret_if.ret_valid); end
            tick();
         end else begin
            checks += 2;
            if (ret_if.ret_valid !== 1'b1) begin fails++; $display("[TB] FAIL batch_latency: got ret_valid=%b, required 1", ret_if.ret_valid); end
            if (ret_if.ret_count !== 5'd4) begin fails++; $display("[TB] FAIL batch_count: got %0d, required 4", ret_if.ret_count); end
            tick();
            checks += 2;
            if (pending !== 5'd0) begin fails++; $display("[TB] FAIL batch_drain: got pending=%0d, required 0", pending); end
            if (ret_if.ret_valid !== 1'b0) begin fails++; $display("[TB] FAIL batch_done: got ret_valid=%b, required 0", ret_if.ret_valid); end
         end
      end
      check_queue_empty("batch_queue");
   endtask

   task automatic test_back_to_back();
      ret_if.ret_ready = 1'b0;
      free_in          = 1'b1;
      repeat (9) tick();
      free_in = 1'b0;
      checks += 3;
      if (pending !== 5'd9) begin fails++; $display("[TB] FAIL b2b_pending: got %0d, required 9", pending); end
      if (ret_if.ret_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_held_valid: got %b, required 1", ret_if.ret_valid); end
      if (ret_if.ret_count !== 5'd4) begin fails++; $display("[TB] FAIL b2b_held_count: got %0d, required 4", ret_if.ret_count); end
      exp_q.push_back(4);
      exp_q.push_back(4);
      ret_if.ret_ready = 1'b1;
      tick();
      checks += 2;
      if (ret_if.ret_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_no_bubble: got ret_valid=%b, required 1", ret_if.ret_valid); end
      if (pending !== 5'd5) begin fails++; $display("[TB] FAIL b2b_mid_pending: got %0d, required 5", pending); end
      tick();
      checks += 2;
      if (ret_if.ret_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_end_valid: got %b, required 0", ret_if.ret_valid); end
      if (pending !== 5'd1) begin fails++; $display("[TB] FAIL b2b_end_pending: got %0d, required 1", pending); end
      check_queue_empty("b2b_queue");
   endtask

   task automatic test_free_held();
      int xfers = 0;
      int p0;
      bit xfer;
      ret_if.ret_ready = 1'b1;
      free_in          = 1'b1;
      for (int c = 0; c < 12; c++) begin
         xfer = ret_if.ret_valid && ret_if.ret_ready;
         p0   = int'(pending);
         if (xfer) begin
            exp_q.push_back(4);
            xfers++;
         end
         tick();
         checks++;
         if (xfer && pending !== 5'(p0 - 3)) begin
            fails++;
            $display("[TB] FAIL held_net[%0d]: got pending=%0d, required %0d", c, pending, p0 - 3);
         end else if (!xfer && pending !== 5'(p0 + 1)) begin
            fails++;
            $display("[TB] FAIL held_inc[%0d]: got pending=%0d, required %0d", c, pending, p0 + 1);
         end
      end
      free_in = 1'b0;
      checks += 2;
      if (xfers != 3) begin fails++; $display("[TB] FAIL held_transfers: got %0d, required 3", xfers); end
      if (err_ovf !== 1'b0) begin fails++; $display("[TB] FAIL held_err: got %b, required 0", err_ovf); end
      check_queue_empty("held_queue");
   endtask

   task automatic test_overflow();
      reset_dut();
      ret_if.ret_ready = 1'b0;
      free_in          = 1'b1;
      repeat (16) tick();
      checks += 2;
      if (pending !== 5'd16) begin fails++; $display("[TB] FAIL ovf_full: got pending=%0d, required 16", pending); end
      if (err_ovf !== 1'b0) begin fails++; $display("[TB] FAIL ovf_early: got err_ovf=%b, required 0", err_ovf); end
      tick();
      free_in = 1'b0;
      checks += 2;
      if (pending !== 5'd16) begin fails++; $display("[TB] FAIL ovf_sat: got pending=%0d, required 16", pending); end
      if (err_ovf !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set: got err_ovf=%b, required 1", err_ovf); end
      tick();
      tick();
      checks++;
      if (err_ovf !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky: got err_ovf=%b, required 1", err_ovf); end
      #2;
      rst = 1'b0;
      #1;
      checks += 4;
      if (ret_if.ret_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_valid: got %b, required 0", ret_if.ret_valid); end
      if (ret_if.ret_count !== 5'd0) begin fails++; $display("[TB] FAIL async_count: got %0d, required 0", ret_if.ret_count); end
      if (pending !== 5'd0)          begin fails++; $display("[TB] FAIL async_pending: got %0d, required 0", pending); end
      if (err_ovf !== 1'b0)          begin fails++; $display("[TB] FAIL async_err: got %b, required 0", err_ovf); end
      exp_q.delete();
      tick();
      rst = 1'b1;
      tick();
      checks += 2;
      if (ret_if.ret_valid !== 1'b1) begin fails++; $display("[TB] FAIL readvertise_valid: got %b, required 1", ret_if.ret_valid); end
      if (ret_if.ret_count !== 5'd16) begin fails++; $display("[TB] FAIL readvertise_count: got %0d, required 16", ret_if.ret_count); end
      exp_q.push_back(16);
      ret_if.ret_ready = 1'b1;
      tick();
      checks++;
      if (ret_if.ret_valid !== 1'b0) begin fails++; $display("[TB] FAIL readvertise_ack: got ret_valid=%b, required 0", ret_if.ret_valid); end
      check_queue_empty("readvertise_queue");
   endtask

   task automatic test_timeout();
      reset_dut();
      free_in = 1'b1;
      tick();
      tick();
      free_in = 1'b0;
      checks++;
      if (pending !== 5'd2) begin fails++; $display("[TB] FAIL timeout_pending: got %0d, required 2", pending); end
`ifdef CREDIT_RETURN_TIMEOUT_EN
      begin
         int  k    = 0;
         bit  seen = 1'b0;
         exp_q.push_back(2);
         while (!seen && k < 20) begin
            tick();
            k++;
            if (ret_if.ret_valid === 1'b1) seen = 1'b1;
         end
         checks += 2;
         if (!seen || k != 8) begin fails++; $display("[TB] FAIL timeout_latency: got %0d cycles (seen=%b), required 8", k, seen); end
         if (ret_if.ret_count !== 5'd2) begin fails++; $display("[TB] FAIL timeout_count: got %0d, required 2", ret_if.ret_count); end
         tick();
         checks += 2;
         if (pending !== 5'd0) begin fails++; $display("[TB] FAIL timeout_drain: got pending=%0d, required 0", pending); end
         if (ret_if.ret_valid !== 1'b0) begin fails++; $display("[TB] FAIL timeout_done: got ret_valid=%b, required 0", ret_if.ret_valid); end
      end
`else
      begin
         int vcnt = 0;
         repeat (20) begin
            tick();
            if (ret_if.ret_valid === 1'b1) vcnt++;
         end
         checks += 2;
         if (vcnt != 0) begin fails++; $display("[TB] FAIL no_timeout_packet: got %0d valid cycles, required 0", vcnt); end
         if (pending !== 5'd2) begin fails++; $display("[TB] FAIL no_timeout_hold: got pending=%0d, required 2", pending); end
      end
`endif
      check_queue_empty("timeout_queue");
   endtask

   initial begin
      rst              = 1'b0;
      free_in          = 1'b0;
      ret_if.ret_ready = 1'b0;
      $display("[TB] credit_return bench starting");
      test_reset();
      test_batch();
      test_back_to_back();
      test_free_held();
      test_overflow();
      test_timeout();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
